// File: rtl/zbt_display_reader.sv
// ZBT frame-buffer read stage: prefetches packed 4-pixel words along the raster and
// unpacks them into one 9-bit pixel per clock, one cycle behind hcount/vcount.
module zbt_display_reader #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_TOTAL  = 1344,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_TOTAL  = 806
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [35:0] zbt_read_data,
  output logic [18:0] zbt_read_addr,
  output logic        zbt_read_req,
  output logic [8:0]  pixel,
  output logic        pixel_valid
);

  localparam logic [10:0] HAct     = 11'(H_ACTIVE);
  localparam logic [10:0] HActLast = 11'(H_ACTIVE - 1);
  localparam logic [10:0] HReqLim  = 11'(H_ACTIVE - 4);
  localparam logic [10:0] HPre     = 11'(H_TOTAL - 4);
  localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VAct     = 10'(V_ACTIVE);
  localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {StIdle, StPrefetch, StStream} state_e;

  state_e      state_q;
  logic [35:0] cur_word_q;
  logic [9:0]  next_v;
  logic [8:0]  field;

  assign next_v = (vcount == VLast) ? 10'd0 : vcount + 10'd1;

  // Leftmost pixel of the word sits in the top bits.
  always_comb begin
    field = 9'd0;
    unique case (hcount[1:0])
      2'd0: field = cur_word_q[35:27];
      2'd1: field = cur_word_q[26:18];
      2'd2: field = cur_word_q[17:9];
      2'd3: field = cur_word_q[8:0];
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cur_word_q    <= 36'd0;
      zbt_read_addr <= 19'd0;
      zbt_read_req  <= 1'b0;
      pixel         <= 9'd0;
      pixel_valid   <= 1'b0;
    end else begin
      zbt_read_req <= 1'b0;

      if (state_q == StStream && hcount < HAct) begin
        pixel       <= field;
        pixel_valid <= 1'b1;
      end else begin
        pixel       <= 9'd0;
        pixel_valid <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (hcount == HPre && next_v < VAct) begin
            zbt_read_addr <= {1'b0, next_v, 8'd0};
            zbt_read_req  <= 1'b1;
            state_q       <= StPrefetch;
          end
        end
        StPrefetch: begin
          if (hcount == HLast) begin
            cur_word_q <= zbt_read_data;
            state_q    <= StStream;
          end
        end
        StStream: begin
          // Fetch word w+1 at the start of word w; it returns just as word w ends.
          if (hcount[1:0] == 2'd0 && hcount < HReqLim) begin
            zbt_read_addr <= {1'b0, vcount, hcount[9:2] + 8'd1};
            zbt_read_req  <= 1'b1;
          end
          if (hcount[1:0] == 2'd3 && hcount < HActLast) begin
            cur_word_q <= zbt_read_data;
          end
          if (hcount == HActLast) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_zbt_display_reader.sv
// Directed bench for zbt_display_reader: drives the raster, models a two-cycle-latency ZBT
// and scoreboards pixel/request outputs against an independent line-streaming model.
module tb_zbt_display_reader;

  localparam int HA = 1024;
  localparam int HT = 1344;
  localparam int VA = 768;
  localparam int VT = 806;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [35:0] zbt_read_data;
  logic [18:0] zbt_read_addr;
  logic        zbt_read_req;
  logic [8:0]  pixel;
  logic        pixel_valid;

  always #5 clk = ~clk;

  zbt_display_reader #(
    .H_ACTIVE(HA),
    .H_TOTAL (HT),
    .V_ACTIVE(VA),
    .V_TOTAL (VT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hcount       (hcount),
    .vcount       (vcount),
    .zbt_read_data(zbt_read_data),
    .zbt_read_addr(zbt_read_addr),
    .zbt_read_req (zbt_read_req),
    .pixel        (pixel),
    .pixel_valid  (pixel_valid)
  );

  typedef struct {
    logic        v;
    logic [8:0]  p;
    logic        r;
    logic [18:0] a;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          hr, vr, last_h, last_v, reqcnt;
  bit          pf, win_ok, line_streamed;
  logic [18:0] p1, p2, p3;

  function automatic logic [8:0] px(int x, int y);
    if (y == 6 && x < 4) begin
      case (x)
        0:       return 9'h1FF;
        1:       return 9'h000;
        2:       return 9'h155;
        default: return 9'h0AA;
      endcase
    end
    return 9'((x ^ y) & 32'h1FF);
  endfunction

  function automatic logic [35:0] word(logic [18:0] a);
    int y = int'(a[17:8]);
    int w = int'(a[7:0]);
    return {px(4 * w, y), px(4 * w + 1, y), px(4 * w + 2, y), px(4 * w + 3, y)};
  endfunction

  task automatic chk(string tag, logic [35:0] obs, logic [35:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_raster();
    hcount = 11'(hr);
    vcount = 10'(vr);
  endtask

  // One clock: push the expected output for the current inputs, clock, pop and compare.
  task automatic step();
    exp_t e;
    int   nv;
    nv  = (vr == VT - 1) ? 0 : vr + 1;
    e.v = 1'b0;
    e.p = 9'd0;
    e.r = 1'b0;
    e.a = 19'd0;
    if (reset_n) begin
      if (hr == 0) line_streamed = pf;
      e.v = pf && hr < HA;
      e.p = e.v ? px(hr, vr) : 9'd0;
      if (hr == HT - 4 && nv < VA) begin
        e.r = 1'b1;
        e.a = {1'b0, 10'(nv), 8'd0};
        pf  = 1'b1;
      end else if (pf && (hr % 4) == 0 && hr < HA - 4) begin
        e.r = 1'b1;
        e.a = {1'b0, 10'(vr), 8'((hr >> 2) + 1)};
      end
      if (hr == HA - 1) pf = 1'b0;
    end else begin
      pf     = 1'b0;
      win_ok = 1'b0;
    end
    sb.push_back(e);
    last_h = hr;
    last_v = vr;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("pixel_valid", 36'(pixel_valid), 36'(e.v));
    chk("pixel", 36'(pixel), 36'(e.p));
    chk("zbt_read_req", 36'(zbt_read_req), 36'(e.r));
    if (e.r) chk("zbt_read_addr", 36'(zbt_read_addr), 36'(e.a));
    if (zbt_read_req) reqcnt++;
    p3 = p2;
    p2 = p1;
    p1 = zbt_read_addr;
    zbt_read_data = word(p3);
    hr++;
    if (hr == HT) begin
      hr = 0;
      vr = (vr == VT - 1) ? 0 : vr + 1;
    end
    drive_raster();
    if (hr == 1100) begin
      if (win_ok) chk("reqs_per_line", 36'(reqcnt), line_streamed ? 36'd256 : 36'd0);
      reqcnt = 0;
      win_ok = 1'b1;
    end
  endtask

  task automatic run_to(int h, int v);
    int n = 0;
    while (!(hr == h && vr == v) && n < 20000) begin
      step();
      n++;
    end
    chk("run_to_reached", 36'(hr == h && vr == v), 36'd1);
  endtask

  // Only used while the reader is idle in horizontal blanking.
  task automatic goto_raster(int h, int v);
    hr     = h;
    vr     = v;
    win_ok = 1'b0;
    reqcnt = 0;
    drive_raster();
  endtask

  initial begin
    int n;
    reset_n       = 1'b0;
    pf            = 1'b0;
    win_ok        = 1'b0;
    line_streamed = 1'b0;
    reqcnt        = 0;
    p1            = 19'd0;
    p2            = 19'd0;
    p3            = 19'd0;
    zbt_read_data = 36'd0;
    goto_raster(1000, 98);
    #1;
    chk("reset_addr", 36'(zbt_read_addr), 36'd0);
    chk("reset_req", 36'(zbt_read_req), 36'd0);
    chk("reset_pixel", 36'(pixel), 36'd0);
    chk("reset_valid", 36'(pixel_valid), 36'd0);
    step();
    step();
    reset_n = 1'b1;

    // Asynchronous reset in the middle of a streamed line.
    run_to(500, 100);
    chk("pre_reset_valid", 36'(pixel_valid), 36'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_addr", 36'(zbt_read_addr), 36'd0);
    chk("async_rst_req", 36'(zbt_read_req), 36'd0);
    chk("async_rst_pixel", 36'(pixel), 36'd0);
    chk("async_rst_valid", 36'(pixel_valid), 36'd0);
    step();
    step();
    reset_n = 1'b1;
    n = 0;
    while (!pixel_valid && n < 3000) begin
      step();
      n++;
    end
    chk("first_valid_h", 36'(last_h), 36'd0);
    chk("first_valid_v", 36'(last_v), 36'd101);
    run_to(1100, 101);

    // Prefetch of line 6 and unpacking of its first word.
    goto_raster(1330, 5);
    run_to(1340, 5);
    step();
    chk("prefetch_addr", 36'(zbt_read_addr), 36'h00600);
    chk("prefetch_req", 36'(zbt_read_req), 36'd1);
    step();
    chk("prefetch_req_one_cycle", 36'(zbt_read_req), 36'd0);
    run_to(0, 6);
    step();
    chk("unpack_f0", 36'(pixel), 36'h1FF);
    step();
    chk("unpack_f1", 36'(pixel), 36'h000);
    step();
    chk("unpack_f2", 36'(pixel), 36'h155);
    step();
    chk("unpack_f3", 36'(pixel), 36'h0AA);

    // Line end behaviour.
    run_to(1016, 6);
    step();
    chk("last_req", 36'(zbt_read_req), 36'd1);
    chk("last_req_addr", 36'(zbt_read_addr), 36'h006FF);
    run_to(1020, 6);
    step();
    chk("no_req_1020", 36'(zbt_read_req), 36'd0);
    run_to(1023, 6);
    step();
    chk("valid_at_1023", 36'(pixel_valid), 36'd1);
    step();
    chk("valid_after_1023", 36'(pixel_valid), 36'd0);
    run_to(1100, 6);

    // Vertical wrap: line 805 prefetches line 0, then sweep lines 0..2.
    goto_raster(1330, 805);
    run_to(1340, 805);
    step();
    chk("wrap_addr", 36'(zbt_read_addr), 36'h00000);
    chk("wrap_req", 36'(zbt_read_req), 36'd1);
    run_to(1100, 2);

    // Last active line and into vertical blanking.
    goto_raster(1330, 764);
    run_to(1340, 767);
    step();
    chk("no_prefetch_767", 36'(zbt_read_req), 36'd0);
    run_to(1100, 770);

    // Longer sweep across the frame wrap.
    goto_raster(1200, 803);
    run_to(1100, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
